calc_alu: RTL and testbench
===========================

Name: calc_alu

Overview:
- Arithmetic unit of the UART calculator. It sits between the command parser and the result formatter.
- On a parser_done start event it latches two 16-bit operands, an operator code and a data type.
- It computes add, subtract, multiply or divide, and returns a 32-bit result with a one-cycle alu_done pulse.
- Add and subtract are single-cycle; multiply and divide are iterative, one step per clock over 16 steps.

Parameters:
- W, 16, operand width; result width is 2*W.

Ports:
- clk  in  1  system clock, rising-edge active.
- n_rst  in  1  asynchronous active-low reset.
- dtype  in  4  data type: 4'h1 = signed two's complement; every other value = unsigned.
- operator  in  5  5'h01 add, 5'h02 sub, 5'h03 mul, 5'h04 div; other values invalid.
- src1  in  16  first operand (minuend, multiplicand, dividend).
- src2  in  16  second operand (subtrahend, multiplier, divisor).
- parser_done  in  1  level from parser; its 0->1 transition requests an operation.
- alu_done  out  1  one-cycle pulse: calc_res is valid.
- calc_res  out  32  result; holds its value until the next completion.

Behaviour:
- Reset (n_rst=0, asynchronous):
  - state=IDLE; alu_done=0; calc_res=0; parser_done delay register=0; all internal registers cleared.
  - Reset mid-operation aborts the operation with no alu_done.
- Start detection:
  - Register parser_done_d each clock.
  - Start occurs at edge k when parser_done=1, parser_done_d=0 and state=IDLE.
  - At edge k, latch dtype, operator, src1 and src2.
  - While busy, further edges and input changes are ignored.
  - parser_done falling mid-operation has no effect.
  - Level held high never retriggers.
- States:
  - IDLE -> ADDSUB (op 1/2 or invalid), MUL (op 3) or DIV (op 4).
  - ADDSUB -> DONE.
  - MUL and DIV -> DONE after 16 steps.
  - DONE -> IDLE.
- alu_done:
  - Registered; high for exactly the one cycle while in DONE.
  - calc_res is updated on the same edge that enters DONE.
- Latency:
  - add/sub/invalid: alu_done high in the cycle after edge k+1.
  - mul/div: alu_done high in the cycle after edge k+17 (steps at edges k+1..k+16).
- Add/sub:
  - Operands are extended to 32 bits: sign-extended if dtype=1, zero-extended otherwise.
  - The 32-bit sum or difference is returned. Unsigned negative differences wrap to 32-bit two's complement, e.g. 2-3 = 32'hFFFFFFFF.
- Multiply:
  - Signed (dtype=1): radix-2 Booth over 16 steps; full 32-bit two's-complement product.
  - Unsigned: shift-add over 16 steps; full 32-bit product.
- Divide:
  - Restoring division over 16 steps on magnitudes.
  - calc_res[15:0]=quotient, calc_res[31:16]=remainder.
  - Signed: quotient truncates toward zero, its sign is sign(src1) xor sign(src2); the remainder takes the sign of the dividend.
  - Divide by zero: quotient=16'hFFFF, remainder=src1, normal latency.
- Invalid operator: calc_res=0 and alu_done pulses with add/sub latency.
- Corner cases:
  - Signed -32768 * -32768 = 32'h40000000.
  - Signed -32768 / -1: quotient 16'h8000 (wrap), remainder 0.

Decomposition:
- Shared package calc_pkg holds:
  - operator constants OP_ADD=5'h01, OP_SUB=5'h02, OP_MUL=5'h03, OP_DIV=5'h04;
  - DT_SIGNED=4'h1;
  - the state enum.
- One natural sub-module, calc_alu_div: iterative 16-step restoring divider with start/done, instantiated by calc_alu.
- Multiply, add/sub and control stay in the top.

Test Plan:
- Unsigned add: dtype=2, op=01, src1=7, src2=2, parser_done rises -> single alu_done pulse, calc_res=32'h00000009.
- Signed sub: dtype=1, op=02, 8-4 -> 32'h00000004; then unsigned 2-3 -> 32'hFFFFFFFF.
- Unsigned mul: dtype=2, op=03, 7*3, parser_done held high 10 cycles -> alu_done exactly once at start+18 cycles, calc_res=32'h00000015.
- Signed Booth mul: dtype=1, op=03, src1=16'h0006, src2=16'hFFFB -> calc_res=32'hFFFFFFE2 (-30). Also -32768*-32768 -> 32'h40000000.
- Divide: dtype=2, op=04, 7/3 -> calc_res=32'h00010002. Signed -7/2 -> quotient 16'hFFFD, remainder 16'hFFFF. Divide by zero with src1=5 -> 32'h0005FFFF.
- Control:
  - assert n_rst low mid-multiply -> alu_done never pulses, calc_res=0;
  - parser_done held high across completion -> no second operation;
  - invalid op 5'h1F -> calc_res=0 with alu_done.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the calculator arithmetic unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package calc_pkg;

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MUL = 5'h03;
  localparam logic [4:0] OP_DIV = 5'h04;

  localparam logic [3:0] DT_SIGNED = 4'h1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDSUB,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/calc_alu_div.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Latency: start sampled at edge k, W steps at edges k+1..k+W, done pulses in the cycle after edge k+W.
// Backpressure: none; a start while busy restarts the division, so the caller must only start when idle.
//
// Ports:
//   clk, n_rst          clock, async active-low reset
//   start               load dividend/divisor and begin
//   dividend, divisor   unsigned magnitudes
//   done                one-cycle pulse, quotient/remainder valid
//   quotient, remainder results (held until next start)
module calc_alu_div #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Partial remainder with the next dividend bit shifted in; one bit wider
  // than the remainder so the trial compare never overflows.
  logic [W:0] shifted;
  logic       fits;

  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    fits    = (shifted >= {1'b0, dvs_q});

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Restoring step: keep the subtraction only when it does not go negative.
      rem_d = fits ? W'(shifted - {1'b0, dvs_q}) : shifted[W-1:0];
      quo_d = {quo_q[W-2:0], fits};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/calc_alu.sv
// Calculator arithmetic unit: add/sub/mul/div on two W-bit operands, 2W-bit result.
// Latency: add/sub/invalid done 2 cycles after start edge k (after edge k+1); mul/div after edge k+17.
// Backpressure: none; starts are accepted only in IDLE, everything else while busy is ignored.
//
// Ports:
//   clk, n_rst    clock, async active-low reset
//   dtype         4'h1 signed, anything else unsigned
//   operator      5'h01 add, 5'h02 sub, 5'h03 mul, 5'h04 div, others give result 0
//   src1, src2    operands (latched on the parser_done rising edge)
//   parser_done   level; its 0->1 transition starts an operation
//   alu_done      one-cycle pulse when calc_res is updated
//   calc_res      result, held until the next completion
module calc_alu
  import calc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic [3:0]     dtype,
  input  logic [4:0]     operator,
  input  logic [W-1:0]   src1,
  input  logic [W-1:0]   src2,
  input  logic           parser_done,
  output logic           alu_done,
  output logic [2*W-1:0] calc_res
);

  localparam int CW = $clog2(W + 1);

  state_t         state_q, state_d;
  logic           pdone_dly_q, pdone_dly_d;
  logic           sgn_q, sgn_d;
  logic [4:0]     op_q, op_d;
  logic [W-1:0]   src1_q, src1_d;
  logic [W-1:0]   src2_q, src2_d;
  logic           alu_done_q, alu_done_d;
  logic [2*W-1:0] calc_res_q, calc_res_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Multiplier datapath: {mul_hi, mul_lo} is the shifting product register.
  // mul_hi carries one extra bit for the add carry (unsigned) or to keep the
  // Booth partial product exact when the multiplicand is the most negative value.
  logic [W:0]     mul_hi_q, mul_hi_d;
  logic [W-1:0]   mul_lo_q, mul_lo_d;
  logic           mul_qm1_q, mul_qm1_d;

  logic           start;
  logic           sgn_in;
  logic [W-1:0]   src1_mag, src2_mag;
  logic           div_start;
  logic           div_done;
  logic [W-1:0]   div_quo, div_rem;

  logic [W:0]     m_ext;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] a_ext, b_ext;
  logic [W-1:0]   quo_res, rem_res;

  calc_alu_div #(.W(W)) u_div (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (div_start),
    .dividend  (src1_mag),
    .divisor   (src2_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    // Start uses the live inputs so the divider can load on the same edge
    // that the operands are latched here.
    start    = parser_done && !pdone_dly_q && (state_q == ST_IDLE);
    sgn_in   = (dtype == DT_SIGNED);
    src1_mag = (sgn_in && src1[W-1]) ? -src1 : src1;
    src2_mag = (sgn_in && src2[W-1]) ? -src2 : src2;

    // Add/sub operand extension.
    a_ext = sgn_q ? {{W{src1_q[W-1]}}, src1_q} : {{W{1'b0}}, src1_q};
    b_ext = sgn_q ? {{W{src2_q[W-1]}}, src2_q} : {{W{1'b0}}, src2_q};

    // One multiply step: Booth recoding of {lo[0], q-1} when signed,
    // plain conditional add of the multiplicand when unsigned.
    m_ext = sgn_q ? {src1_q[W-1], src1_q} : {1'b0, src1_q};
    if (sgn_q) begin
      case ({mul_lo_q[0], mul_qm1_q})
        2'b01:   mul_sum = mul_hi_q + m_ext;
        2'b10:   mul_sum = mul_hi_q - m_ext;
        default: mul_sum = mul_hi_q;
      endcase
    end else begin
      mul_sum = mul_lo_q[0] ? (mul_hi_q + m_ext) : mul_hi_q;
    end

    // Divider returns magnitudes; restore signs from the latched operands.
    quo_res = (sgn_q && (src1_q[W-1] ^ src2_q[W-1])) ? -div_quo : div_quo;
    rem_res = (sgn_q && src1_q[W-1]) ? -div_rem : div_rem;

    state_d     = state_q;
    pdone_dly_d = parser_done;
    sgn_d       = sgn_q;
    op_d        = op_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    alu_done_d  = 1'b0;
    calc_res_d  = calc_res_q;
    cnt_d       = cnt_q;
    mul_hi_d    = mul_hi_q;
    mul_lo_d    = mul_lo_q;
    mul_qm1_d   = mul_qm1_q;
    div_start   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sgn_d     = sgn_in;
          op_d      = operator;
          src1_d    = src1;
          src2_d    = src2;
          cnt_d     = '0;
          mul_hi_d  = '0;
          mul_lo_d  = src2;
          mul_qm1_d = 1'b0;
          case (operator)
            OP_MUL: state_d = ST_MUL;
            OP_DIV: begin
              state_d   = ST_DIV;
              div_start = 1'b1;
            end
            default: state_d = ST_ADDSUB;
          endcase
        end
      end

      ST_ADDSUB: begin
        case (op_q)
          OP_ADD:  calc_res_d = a_ext + b_ext;
          OP_SUB:  calc_res_d = a_ext - b_ext;
          default: calc_res_d = '0;
        endcase
        alu_done_d = 1'b1;
        state_d    = ST_DONE;
      end

      ST_MUL: begin
        if (cnt_q == CW'(W)) begin
          calc_res_d = {mul_hi_q[W-1:0], mul_lo_q};
          alu_done_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          // Shift right by one; top bit is the sign (Booth) or zero (unsigned,
          // where the sum never exceeds W+1 bits).
          mul_hi_d  = {sgn_q & mul_sum[W], mul_sum[W:1]};
          mul_lo_d  = {mul_sum[0], mul_lo_q[W-1:1]};
          mul_qm1_d = mul_lo_q[0];
          cnt_d     = cnt_q + CW'(1);
        end
      end

      ST_DIV: begin
        if (div_done) begin
          if (src2_q == '0) begin
            calc_res_d = {src1_q, {W{1'b1}}};
          end else begin
            calc_res_d = {rem_res, quo_res};
          end
          alu_done_d = 1'b1;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      pdone_dly_q <= 1'b0;
      sgn_q       <= 1'b0;
      op_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      alu_done_q  <= 1'b0;
      calc_res_q  <= '0;
      cnt_q       <= '0;
      mul_hi_q    <= '0;
      mul_lo_q    <= '0;
      mul_qm1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pdone_dly_q <= pdone_dly_d;
      sgn_q       <= sgn_d;
      op_q        <= op_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      alu_done_q  <= alu_done_d;
      calc_res_q  <= calc_res_d;
      cnt_q       <= cnt_d;
      mul_hi_q    <= mul_hi_d;
      mul_lo_q    <= mul_lo_d;
      mul_qm1_q   <= mul_qm1_d;
    end
  end

  assign alu_done = alu_done_q;
  assign calc_res = calc_res_q;

endmodule

// File: tb/tb_calc_alu.sv
// Self-checking bench for calc_alu: driver pushes expected results, monitor pops on alu_done.
// Expected completion cycle is checked along with the value; late completions are flagged.
// Hold, reset-value and no-retrigger behaviour are checked every cycle by the monitor.
module tb_calc_alu;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  dtype;
  logic [4:0]  operator;
  logic [15:0] src1;
  logic [15:0] src2;
  logic        parser_done;
  logic        alu_done;
  logic [31:0] calc_res;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  calc_alu #(.W(16)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .dtype       (dtype),
    .operator    (operator),
    .src1        (src1),
    .src2        (src2),
    .parser_done (parser_done),
    .alu_done    (alu_done),
    .calc_res    (calc_res)
  );

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_res = 32'h0;

  // Reference model from the arithmetic definitions, not the datapath.
  function automatic logic [31:0] model(input logic [3:0] dt, input logic [4:0] op,
                                        input logic [15:0] a, input logic [15:0] b);
    bit          s;
    int          sa, sbv, q, r;
    longint      p;
    logic [31:0] res;
    s   = (dt == 4'h1);
    sa  = s ? int'($signed(a)) : int'(a);
    sbv = s ? int'($signed(b)) : int'(b);
    res = 32'h0;
    case (op)
      5'h01: res = sa + sbv;
      5'h02: res = sa - sbv;
      5'h03: begin
        p   = longint'(sa) * longint'(sbv);
        res = p[31:0];
      end
      5'h04: begin
        if (b == 16'h0) begin
          res = {a, 16'hFFFF};
        end else begin
          q   = sa / sbv;
          r   = sa % sbv;
          res = {r[15:0], q[15:0]};
        end
      end
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        n_chk++;
        if (alu_done !== 1'b0 || calc_res !== 32'h0) begin
          n_fail++;
          $display("FAIL reset_state: alu_done=%b calc_res=%h, required 0/00000000", alu_done, calc_res);
        end
        last_res = 32'h0;
      end else if (alu_done === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: alu_done at cycle %0d with no operation pending, calc_res=%h", cyc, calc_res);
        end else begin
          e = sb.pop_front();
          n_chk++;
          if (calc_res !== e.res) begin
            n_fail++;
            $display("FAIL result: calc_res=%h, required %h (cycle %0d)", calc_res, e.res, cyc);
          end
          n_chk++;
          if (cyc != e.due) begin
            n_fail++;
            $display("FAIL latency: alu_done at cycle %0d, required cycle %0d", cyc, e.due);
          end
          last_res = e.res;
        end
      end else begin
        n_chk++;
        if (alu_done !== 1'b0 || calc_res !== last_res) begin
          n_fail++;
          $display("FAIL hold: alu_done=%b calc_res=%h, required 0/%h (cycle %0d)", alu_done, calc_res, last_res, cyc);
        end
        if (sb.size() > 0 && cyc > sb[0].due) begin
          n_chk++;
          n_fail++;
          $display("FAIL timeout: no alu_done by cycle %0d, expected result %h", sb[0].due, sb[0].res);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Issue one operation: parser_done rises, is held for 'hold' cycles (possibly
  // past completion), inputs are scrambled while busy.
  task automatic do_op(input logic [3:0] dt, input logic [4:0] op,
                       input logic [15:0] a, input logic [15:0] b, input int hold);
    exp_t e;
    int   i;
    @(negedge clk);
    dtype       = dt;
    operator    = op;
    src1        = a;
    src2        = b;
    parser_done = 1'b1;
    e.res = model(dt, op, a, b);
    e.due = cyc + ((op == 5'h03 || op == 5'h04) ? 18 : 2);
    sb.push_back(e);
    @(negedge clk);
    dtype    = 4'($urandom);
    operator = 5'($urandom);
    src1     = 16'($urandom);
    src2     = 16'($urandom);
    i = 1;
    while ((i < hold || cyc <= e.due) && i < 100) begin
      if (i >= hold) parser_done = 1'b0;
      @(negedge clk);
      i++;
    end
    parser_done = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  function automatic logic [15:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [3:0] dt;
    logic [4:0] op;
    n_rst       = 1'b0;
    parser_done = 1'b0;
    dtype       = 4'h0;
    operator    = 5'h0;
    src1        = 16'h0;
    src2        = 16'h0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases.
    do_op(4'h2, 5'h01, 16'd7, 16'd2, 1);
    do_op(4'h1, 5'h02, 16'd8, 16'd4, 2);
    do_op(4'h2, 5'h02, 16'd2, 16'd3, 1);
    do_op(4'h2, 5'h03, 16'd7, 16'd3, 10);
    do_op(4'h1, 5'h03, 16'h0006, 16'hFFFB, 1);
    do_op(4'h1, 5'h03, 16'h8000, 16'h8000, 1);
    do_op(4'h2, 5'h03, 16'hFFFF, 16'hFFFF, 1);
    do_op(4'h2, 5'h04, 16'd7, 16'd3, 1);
    do_op(4'h1, 5'h04, 16'hFFF9, 16'd2, 1);
    do_op(4'h2, 5'h04, 16'd5, 16'd0, 1);
    do_op(4'h1, 5'h04, 16'hFFFB, 16'd0, 1);
    do_op(4'h1, 5'h04, 16'h8000, 16'hFFFF, 1);
    do_op(4'h1, 5'h1F, 16'd9, 16'd9, 1);
    do_op(4'h2, 5'h01, 16'hFFFF, 16'h0001, 30);
    do_op(4'h1, 5'h04, 16'd7, 16'hFFFE, 30);

    // Reset in the middle of a multiply: no completion may appear, result reads 0.
    @(negedge clk);
    dtype       = 4'h2;
    operator    = 5'h03;
    src1        = 16'd7;
    src2        = 16'd3;
    parser_done = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 n_rst = 1'b0;
    parser_done = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (25) @(negedge clk);
    do_op(4'h2, 5'h01, 16'd1, 16'd1, 1);

    // Randomised operations.
    for (int n = 0; n < 250; n++) begin
      dt = ($urandom_range(0, 1) == 0) ? 4'h1 : 4'($urandom);
      if ($urandom_range(0, 9) == 9) op = 5'($urandom);
      else op = 5'($urandom_range(1, 4));
      do_op(dt, op, rand_opnd(), rand_opnd(), $urandom_range(1, 25));
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
